// File: rtl/ysyx_23060171_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_ifu -- instruction fetch unit of the single-issue NPC core.
//
// Holds the PC, fetches one instruction word at a time from instruction
// memory, registers it and hands it to the decoder. It then waits for the
// next PC from execute/writeback before fetching again. Exactly one
// instruction is in flight at any time.
//
// Ports:
//   clk             core clock, all state changes on the rising edge
//   rst             asynchronous, active-low reset
//   imem_req_*      fetch request (valid/ready, addr = pc)
//   imem_rsp_*      fetch response (valid, data, err qualified by valid)
//   inst_valid/ready  instruction handshake towards the decoder
//   inst, inst_pc   registered instruction and its PC
//   opcode/f3/f7/f12  field slices of the registered instruction
//   npc_valid, npc  next PC from downstream (held until consumed)
//   fetch_err       sticky fault flag (response error or misaligned npc)
//   fetch_cnt       number of completed (error-free) fetches, wraps
//   dbg_state       current FSM state for debug/checkers
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. The producer keeps valid and its payload stable until the
// transfer; the consumer may raise or lower ready freely.
// ---------------------------------------------------------------------------
module ysyx_23060171_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      f3,
    output logic [6:0]      f7,
    output logic [11:0]     f12,

    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,

    output logic            fetch_err,
    output logic [31:0]     fetch_cnt,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        OUT  = 3'd3,
        NPC  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t          state;
    logic [XLEN-1:0] pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            inst      <= NOP;
            inst_pc   <= RESET_PC;
            fetch_err <= 1'b0;
            fetch_cnt <= 32'd0;
        end else begin
            case (state)
                IDLE: state <= REQ;

                REQ: begin
                    if (imem_req_ready) begin
                        state <= RESP;
                    end
                end

                // Responses are only looked at here, so a stale response
                // arriving in any other state is dropped.
                RESP: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            inst      <= imem_rsp_data;
                            inst_pc   <= pc;
                            fetch_cnt <= fetch_cnt + 32'd1;
                            state     <= OUT;
                        end
                    end
                end

                // npc_valid is deliberately not sampled here, even on the
                // handshake cycle; downstream holds it until NPC picks it up.
                OUT: begin
                    if (inst_ready) begin
                        state <= NPC;
                    end
                end

                NPC: begin
                    if (npc_valid) begin
                        if (npc[1:0] == 2'b00) begin
                            pc    <= npc;
                            state <= REQ;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end
                    end
                end

                ERR: state <= ERR;

                default: state <= IDLE;
            endcase
        end
    end

    // Valids decode directly from the state register, so they drop to 0 the
    // moment reset forces the state back to IDLE.
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == OUT);

    assign opcode    = inst[6:0];
    assign f3        = inst[14:12];
    assign f7        = inst[31:25];
    assign f12       = inst[31:20];
    assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_23060171_ifu.sv
// ---------------------------------------------------------------------------
// Directed testbench for ysyx_23060171_ifu.
// Inputs are driven 1 time unit after a rising edge and outputs are checked
// at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_ysyx_23060171_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_REQ  = 3'd1;
    localparam logic [2:0]  S_RESP = 3'd2;
    localparam logic [2:0]  S_NPC  = 3'd4;
    localparam logic [2:0]  S_ERR  = 3'd5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [11:0] f12;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_err;
    logic [31:0] fetch_cnt;
    logic [2:0]  dbg_state;

    ysyx_23060171_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .f3             (f3),
        .f7             (f7),
        .f12            (f12),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .fetch_err      (fetch_err),
        .fetch_cnt      (fetch_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check its address against the expected
    // queue, accept it, and return a good response one cycle later.
    task automatic fetch(input logic [31:0] data);
        int n;
        logic [31:0] ea;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_valid", {31'd0, imem_req_valid}, 32'd1);
        ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check("req_addr", imem_req_addr, ea);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("req_once", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = 1'b0;
        tick();
        imem_rsp_valid = 1'b0;
        check("inst_valid", {31'd0, inst_valid}, 32'd1);
        check("inst", inst, data);
    endtask

    // Decoder takes the instruction, then downstream supplies the next PC.
    task automatic consume(input logic [31:0] next_pc);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("out_done", {31'd0, inst_valid}, 32'd0);
        npc_valid = 1'b1;
        npc       = next_pc;
        tick();
        npc_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        #3 rst = 1'b1;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        npc_valid      = 1'b0;
        npc            = 32'h0;

        // Reset values
        #1 rst = 1'b0;
        #10;
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, RST_PC);
        check("rst_addr", imem_req_addr, RST_PC);
        check("rst_err0", {31'd0, fetch_err}, 32'd0);
        check("rst_cnt0", fetch_cnt, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        rst = 1'b1;
        tick();

        // First REQ with request back-pressure for 5 cycles
        check("first_req_state", {29'd0, dbg_state}, {29'd0, S_REQ});
        for (int i = 0; i < 5; i++) begin
            check("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("bp_req_addr", imem_req_addr, RST_PC);
            tick();
        end

        // First fetch: addi x1, x0, 1
        exp_q.push_back(RST_PC);
        fetch(32'h0010_0093);
        check("f1_opcode", {25'd0, opcode}, 32'h13);
        check("f1_f3", {29'd0, f3}, 32'd0);
        check("f1_f12", {20'd0, f12}, 32'h001);
        check("f1_inst_pc", inst_pc, RST_PC);
        check("f1_cnt", fetch_cnt, 32'd1);

        // Sequential flow then a jump target
        consume(32'h8000_0004);
        exp_q.push_back(32'h8000_0004);
        fetch(32'hfe01_0113);
        check("f2_f7", {25'd0, f7}, 32'h7f);
        check("f2_f12", {20'd0, f12}, 32'hfe0);
        check("f2_inst_pc", inst_pc, 32'h8000_0004);
        consume(32'h8000_0100);
        exp_q.push_back(32'h8000_0100);
        fetch(32'h40b5_0533);
        check("f3_opcode", {25'd0, opcode}, 32'h33);
        check("f3_f7", {25'd0, f7}, 32'h20);
        check("f3_inst_pc", inst_pc, 32'h8000_0100);
        check("f3_cnt", fetch_cnt, 32'd3);

        // Decoder stall with npc_valid already held high
        npc_valid = 1'b1;
        npc       = 32'h8000_0104;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_inst", inst, 32'h40b5_0533);
            check("stall_pc", inst_pc, 32'h8000_0100);
            check("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("stall_npc_state", {29'd0, dbg_state}, {29'd0, S_NPC});
        tick();
        npc_valid = 1'b0;
        check("stall_next_req", {31'd0, imem_req_valid}, 32'd1);
        exp_q.push_back(32'h8000_0104);
        fetch(32'h0000_0013);
        check("f4_cnt", fetch_cnt, 32'd4);

        // Fault (b): misaligned npc
        consume(32'h8000_0002);
        check("mis_err", {31'd0, fetch_err}, 32'd1);
        check("mis_state", {29'd0, dbg_state}, {29'd0, S_ERR});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mis_noreq", {31'd0, imem_req_valid}, 32'd0);
            check("mis_pc", imem_req_addr, 32'h8000_0104);
        end
        do_reset();
        check("mis_restart", imem_req_addr, RST_PC);

        // Fault (a): response error
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        imem_rsp_err   = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        check("rerr_err", {31'd0, fetch_err}, 32'd1);
        check("rerr_inst", inst, NOP);
        check("rerr_cnt", fetch_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rerr_noreq", {31'd0, imem_req_valid}, 32'd0);
            check("rerr_noinst", {31'd0, inst_valid}, 32'd0);
        end
        do_reset();
        check("rerr_restart", imem_req_addr, RST_PC);

        // Async reset in the middle of RESP
        exp_q.push_back(RST_PC);
        fetch(32'h0020_0113);
        consume(32'h8000_0008);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("mid_resp_state", {29'd0, dbg_state}, {29'd0, S_RESP});
        #2 rst = 1'b0;
        #1;
        check("mid_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        check("mid_addr", imem_req_addr, RST_PC);
        check("mid_inst", inst, NOP);
        check("mid_inst_pc", inst_pc, RST_PC);
        check("mid_cnt", fetch_cnt, 32'd0);
        tick();
        #2 rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hcafe_f00d;
        tick();
        check("late_state1", {29'd0, dbg_state}, {29'd0, S_REQ});
        tick();
        imem_rsp_valid = 1'b0;
        check("late_state2", {29'd0, dbg_state}, {29'd0, S_REQ});
        check("late_inst", inst, NOP);
        check("late_cnt", fetch_cnt, 32'd0);
        exp_q.push_back(RST_PC);
        fetch(32'h0030_0193);
        check("late_fetch_pc", inst_pc, RST_PC);
        check("late_fetch_cnt", fetch_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060171_ifu.md
Name: ysyx_23060171_ifu

Overview:
- Instruction fetch unit, directly upstream of the decoder in the single-issue NPC core.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request/response pair.
- Registers each fetched instruction, presents it plus split fields (opcode/f3/f7/f12) to the decoder with a valid/ready handshake, then waits for the downstream-computed next PC before fetching again.
- Non-pipelined: exactly one instruction in flight.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, PC/address/instruction width.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction word.
- imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid.
- inst_valid  out  1  instruction available to decoder.
- inst_ready  in  1  decoder consumes instruction.
- inst  out  32  registered instruction.
- inst_pc  out  XLEN  PC of inst.
- opcode  out  7  inst[6:0].
- f3  out  3  inst[14:12].
- f7  out  7  inst[31:25].
- f12  out  12  inst[31:20].
- npc_valid  in  1  next PC from execute/writeback is valid.
- npc  in  XLEN  next PC (pc+4, ALU result or jalr target).
- fetch_err  out  1  sticky fault flag.
- fetch_cnt  out  32  completed-fetch counter.

Behaviour:
- Reset (rst low, async): state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_pc=RESET_PC, fetch_err=0, fetch_cnt=0. All valids=0 while in reset.
- The field outputs are pure slices of the registered inst.
- FSM states: IDLE, REQ, RESP, OUT, NPC, ERR.
- IDLE: unconditionally goes to REQ on the first clock after reset release.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Hold addr stable until imem_req_ready.
  - On handshake, go to RESP.
- RESP:
  - Wait for imem_rsp_valid. The earliest accepted response is the cycle after the request handshake.
  - On rsp with err=0: inst<=rsp_data, inst_pc<=pc, fetch_cnt<=fetch_cnt+1 (wraps 32'hFFFF_FFFF→0), go to OUT.
  - On rsp with err=1: fetch_err<=1, go to ERR, inst unchanged.
- OUT:
  - inst_valid=1. inst and fields are stable until handshake.
  - On inst_ready, go to NPC.
- NPC:
  - Wait for npc_valid.
  - If npc[1:0]==0: pc<=npc, go to REQ.
  - If npc[1:0]!=0 (misaligned): fetch_err<=1, pc unchanged, go to ERR.
- ERR: terminal. No requests, inst_valid=0, fetch_err=1 until reset.
- Ignored inputs:
  - imem_rsp_valid outside RESP is ignored.
  - npc_valid outside NPC is ignored, including a same-cycle arrival with the OUT handshake. Downstream must hold npc_valid until consumed.
- Latency with zero-wait memory (ready=1, response 1 cycle later): REQ@t, RESP@t+1 captures, inst_valid@t+2; 4 cycles per instruction minimum with an immediate npc.
- Reset asserted mid-operation (any state) returns to IDLE immediately. A pending memory response after reset release is ignored unless the FSM is in RESP for a new request; the memory side must drop outstanding requests on reset.
- Back-pressure:
  - A held imem_req_ready=0 keeps REQ indefinitely.
  - A held inst_ready=0 keeps OUT with no output change.

Test Plan:
- Reset release, ready=1, rsp 1 cycle later with data 32'h00100093 → imem_req_addr=32'h8000_0000 at first REQ cycle; inst_valid high 2 cycles after request handshake with opcode=7'b0010011, f3=0, f12=12'h001, inst_pc=32'h8000_0000, fetch_cnt=1.
- Request back-pressure: hold req_ready=0 for 5 cycles → req_valid stays 1 and addr stays 32'h8000_0000; exactly one handshake when ready rises.
- Sequential flow: inst_ready=1, npc=32'h8000_0004, then a jal target npc=32'h8000_0100 → next request addrs are 32'h8000_0004 then 32'h8000_0100; fetch_cnt=3.
- Decoder stall: inst_ready=0 for 4 cycles with npc_valid=1 throughout → inst/inst_pc unchanged and no new request; after ready, next request at npc one cycle after entering NPC.
- Faults: (a) rsp_err=1 → fetch_err=1, no further req_valid, inst_valid=0; (b) npc=32'h8000_0002 → fetch_err=1 and pc stays unchanged. Each case is then followed by reset, which clears fetch_err and restarts at 32'h8000_0000.
- Async reset asserted mid-RESP, between clock edges → outputs go to reset values immediately; a late rsp_valid after release is ignored; first request after release is addr 32'h8000_0000.
